// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared pipeline types and constants for the hazard controller
package hazard_controller_pkg;
    typedef enum logic [1:0] {HZ_RUN, HZ_MD_WAIT, HZ_MD_DONE} hz_state_e;
    typedef enum logic [1:0] {FU_SRC_REG, FU_SRC_MEM, FU_SRC_WB} fu_src_e;
    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: ID/EX hazard inputs and stage enable/flush outputs of the hazard controller
interface hazard_controller_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
    logic             id_uses_rs1_i, id_uses_rs2_i;
    logic             ex_reg_we_i, ex_is_load_i, ex_md_i, branch_taken_i, md_done_i;
    logic             if_stall_o, id_stall_o, ex_stall_o, ex_bubble_o, if_id_flush_o;
    logic             md_start_o, md_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    modport master (
        output id_rs1_i, id_rs2_i, ex_rd_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_reg_we_i, ex_is_load_i, ex_md_i, branch_taken_i, md_done_i,
        input  if_stall_o, id_stall_o, ex_stall_o, ex_bubble_o, if_id_flush_o,
               md_start_o, md_err_o, stall_cnt_o
    );
    modport slave (
        input  id_rs1_i, id_rs2_i, ex_rd_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_reg_we_i, ex_is_load_i, ex_md_i, branch_taken_i, md_done_i,
        output if_stall_o, id_stall_o, ex_stall_o, ex_bubble_o, if_id_flush_o,
               md_start_o, md_err_o, stall_cnt_o
    );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID source read of a register still being loaded by the EX instruction
module load_use_detect
    import hazard_controller_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_we,
    input  logic       ex_is_load,
    output logic       lu
);
    assign lu = ex_is_load && ex_reg_we && ex_rd != REG_X0 &&
                ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush and mul/div hold sequencing (mul/div part under HAZARD_MD_EN)
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    hazard_controller_if.slave hz
);
    logic lu;
    load_use_detect u_lud (
        .rs1(hz.id_rs1_i), .rs2(hz.id_rs2_i),
        .uses_rs1(hz.id_uses_rs1_i), .uses_rs2(hz.id_uses_rs2_i),
        .ex_rd(hz.ex_rd_i), .ex_reg_we(hz.ex_reg_we_i), .ex_is_load(hz.ex_is_load_i),
        .lu(lu)
    );
`ifdef HAZARD_MD_EN
    localparam int WC_W = $clog2(MD_TIMEOUT + 1);
    hz_state_e       state, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            timeout, md_err, run, wait_st;
    assign run     = state == HZ_RUN;
    assign wait_st = state == HZ_MD_WAIT;
    assign timeout = wait_st && !hz.md_done_i && wait_cnt == WC_W'(MD_TIMEOUT - 1);
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HZ_RUN;
        else        state <= state_nxt;
    end
    // next state: a mul/div in RUN enters the wait, done or watchdog leaves it via one DONE cycle
    always_comb begin
        state_nxt = HZ_RUN;
        if (run)          state_nxt = (!hz.branch_taken_i && hz.ex_md_i) ? HZ_MD_WAIT : HZ_RUN;
        else if (wait_st) state_nxt = (hz.md_done_i || timeout) ? HZ_MD_DONE : HZ_MD_WAIT;
    end
    // outputs: branch beats mul/div beats load-use in RUN; WAIT holds everything; DONE releases
    always_comb begin
        hz.if_id_flush_o = run && hz.branch_taken_i;
        hz.md_start_o    = run && !hz.branch_taken_i && hz.ex_md_i;
        hz.ex_stall_o    = wait_st || hz.md_start_o;
        hz.ex_bubble_o   = run && (hz.branch_taken_i || (!hz.ex_md_i && lu));
        hz.if_stall_o    = hz.ex_stall_o || (run && !hz.branch_taken_i && !hz.ex_md_i && lu);
        hz.id_stall_o    = hz.if_stall_o;
    end
    // wait counter runs only while staying in MD_WAIT; sticky error on watchdog expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            md_err   <= 1'b0;
        end else begin
            wait_cnt <= (wait_st && state_nxt == HZ_MD_WAIT) ? wait_cnt + 1'b1 : '0;
            md_err   <= md_err || timeout;
        end
    end
    assign hz.md_err_o = md_err;
`else
    logic unused_md;
    assign unused_md = ^{hz.ex_md_i, hz.md_done_i};
    // outputs: branch flush beats the load-use stall
    always_comb begin
        hz.if_id_flush_o = hz.branch_taken_i;
        hz.ex_bubble_o   = hz.branch_taken_i || lu;
        hz.if_stall_o    = !hz.branch_taken_i && lu;
        hz.id_stall_o    = hz.if_stall_o;
        hz.ex_stall_o    = 1'b0;
        hz.md_start_o    = 1'b0;
    end
    assign hz.md_err_o = 1'b0;
`endif
    logic [CNT_W-1:0] stall_cnt;
    // saturating count of front-end stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         stall_cnt <= '0;
        else if (hz.if_stall_o && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
    assign hz.stall_cnt_o = stall_cnt;
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard sequencer for the five-stage core. Watches ID source registers against the EX-stage destination and issues the one-cycle load-use stall plus bubble that operand forwarding cannot cover. Flushes the front end on a taken branch. Holds IF/ID/EX while a multi-cycle mul/div unit runs, with a watchdog timeout. Sits beside the forwarding logic in the top-level pipeline and drives every stage enable/flush.

## Interface
- MD_TIMEOUT, 64: max cycles in MD_WAIT before abort; legal 2..65535.
- CNT_W, 16: width of the stall performance counter.

Ports (name, direction, width, meaning):
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1_i / id_rs2_i  in  5  source register indices of the instruction in ID.
- id_uses_rs1_i / id_uses_rs2_i  in  1  ID instruction actually reads rs1 / rs2.
- ex_rd_i  in  5  destination of the instruction in EX.
- ex_reg_we_i  in  1  EX instruction writes the register file.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_md_i  in  1  EX instruction is a mul/div.
- branch_taken_i  in  1  branch/jump resolved taken in EX this cycle.
- md_done_i  in  1  mul/div result valid (single-cycle pulse).
- if_stall_o / id_stall_o / ex_stall_o  out  1  hold the PC, IF/ID and ID/EX registers.
- ex_bubble_o  out  1  load NOP into ID/EX at the next edge.
- if_id_flush_o  out  1  squash IF/ID at the next edge.
- md_start_o  out  1  one-cycle start pulse to the mul/div unit.
- md_err_o  out  1  sticky: mul/div timeout occurred.
- stall_cnt_o  out  CNT_W  saturating count of cycles with if_stall_o high.

## Operation
- FSM states: RUN, MD_WAIT, MD_DONE. Reset state is RUN.
- Load-use hazard (`lu`) is asserted when all of the following hold:
  - ex_is_load_i and ex_reg_we_i;
  - ex_rd_i != 0;
  - (id_uses_rs1_i and id_rs1_i == ex_rd_i) or (id_uses_rs2_i and id_rs2_i == ex_rd_i).
- In RUN, priority order:
  - branch_taken_i: if_id_flush_o=1 and ex_bubble_o=1; no stalls; stay in RUN. Overrides `lu` and ex_md_i.
  - ex_md_i: md_start_o=1; if_stall_o, id_stall_o and ex_stall_o all 1; go to MD_WAIT.
  - `lu`: if_stall_o=1, id_stall_o=1, ex_bubble_o=1; stay in RUN. The bubble removes the hazard on the next cycle, so the stall lasts exactly one cycle.
  - Otherwise all outputs are 0.
- MD_WAIT:
  - All three stalls are held high; `lu` and branch_taken_i are ignored.
  - A wait counter increments each cycle.
  - md_done_i: go to MD_DONE.
  - Counter reaches MD_TIMEOUT with no md_done_i: set md_err_o and go to MD_DONE.
- MD_DONE:
  - Stalls are 0, so EX advances with the result.
  - The instruction that moves into EX is treated as new; ex_md_i here is not restarted. The next mul/div is accepted in RUN.
  - Unconditionally go to RUN.
- stall_cnt_o increments on every cycle with if_stall_o=1 and saturates at all-ones.
- md_err_o clears only on reset.

## Timing
- All outputs except md_err_o and stall_cnt_o are combinational from state and inputs (Mealy). There is no input-to-output register.
- md_start_o is high only in the RUN cycle where MD_WAIT is entered, never in MD_WAIT.
- A mul/div with md_done_i on the first MD_WAIT cycle costs 2 stall cycles (entry cycle + 1).
- md_done_i outside MD_WAIT is ignored.
- Reset values: state RUN, wait counter 0, md_err_o 0, stall_cnt_o 0.
- All combinational outputs are 0 during reset, provided ex_md_i, branch_taken_i and the `lu` conditions are 0.
- Reset asserted mid MD_WAIT returns the FSM to RUN immediately. md_start_o is not reissued until a new ex_md_i is seen in RUN.

## Configuration
- HAZARD_MD_EN defined: mul/div sequencing compiled in, as described above.
- HAZARD_MD_EN undefined: the FSM, wait counter and md_err_o logic are removed.
  - md_start_o, ex_stall_o and md_err_o are tied 0.
  - ex_md_i and md_done_i are unused.
  - Only branch flush, load-use stall and stall_cnt_o remain.

## Structure
- Shared pipeline package:
  - state enum hz_state_e (HZ_RUN, HZ_MD_WAIT, HZ_MD_DONE);
  - the existing operand-source constants FU_SRC_REG, FU_SRC_MEM, FU_SRC_WB;
  - REG_X0 = 5'd0.
- One natural sub-module, load_use_detect: purely combinational, producing `lu` from the ID/EX inputs; reused by the verification scoreboard.
- The FSM, wait counter and perf counter stay in hazard_controller.

## Test plan
- Load to x5 in EX; ID reads rs1=5 with id_uses_rs1_i=1 -> if/id stall and ex_bubble_o for exactly 1 cycle; stall_cnt_o goes 0->1.
- Load to x0 in EX; ID reads rs1=0 -> no stall, no bubble.
- branch_taken_i=1 together with a load-use match -> if_id_flush_o=1 and ex_bubble_o=1, stalls 0, state RUN.
- ex_md_i=1, md_done_i 3 cycles after entry -> md_start_o pulses once; stalls high 4 cycles; MD_DONE for 1 cycle; then RUN; stall_cnt_o=4.
- MD_TIMEOUT=8, md_done_i never arrives -> md_err_o set after 8 MD_WAIT cycles; FSM passes through MD_DONE to RUN; md_err_o stays 1.
- rst_n low during MD_WAIT -> state RUN, counters 0, no md_start_o after release. Without HAZARD_MD_EN, ex_md_i=1 -> md_start_o=0 and no stall.
